// File: rtl/bitbakery_pkg.sv
// rtl/bitbakery_pkg.sv - shared minigame interface widths and state codes
package bitbakery_pkg;

  localparam int N_BOTOES = 7;
  localparam int W_ESTADO = 4;
  localparam int W_PONTOS = 3;

  // Index value meaning "no previous target" for the no-repeat rule.
  localparam logic [2:0] SEM_ALVO = 3'd7;

  typedef enum logic [3:0] {
    INICIAL = 4'h0,
    PREPARA = 4'h2,
    ESPERA  = 4'h3,
    MOSTRA  = 4'h4,
    ACERTO  = 4'h5,
    ERRO    = 4'h6,
    PROXIMA = 4'h7,
    FIM     = 4'hF
  } estado_t;

endpackage

// File: rtl/contador_m.sv
// rtl/contador_m.sv - modulo counter with runtime modulus and terminal count
module contador_m #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear_i,
  input  logic         enable_i,
  input  logic [W-1:0] modulo_i,
  output logic         tc_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Terminal count is the last value of the modulus, so an enabled run of
  // modulo_i cycles starting from zero ends on the cycle tc_o is high.
  assign tc_o = (count_q == modulo_i - W'(1));

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = tc_o ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/lfsr_alvo.sv
// rtl/lfsr_alvo.sv - free-running 7-bit LFSR and non-repeating oven index
module lfsr_alvo #(
  parameter logic [6:0] SEED = 7'h5A
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] prev_idx,
  output logic [2:0] idx
);

  logic [6:0] lfsr_q;
  logic [6:0] lfsr_d;
  logic [2:0] t;

  // x^7 + x^6 + 1 is maximal length, so a nonzero seed never reaches zero.
  assign lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign t   = 3'(lfsr_q % 7'd7);
  assign idx = (t == prev_idx) ? ((t == 3'd6) ? 3'd0 : t + 3'd1) : t;

endmodule

// File: rtl/ovengame.sv
// rtl/ovengame.sv - oven reaction minigame: light a random oven, score matching presses
module ovengame
  import bitbakery_pkg::*;
#(
  parameter int         ROUNDS       = 7,
  parameter int         GAP          = 500,
  parameter int         TIMEOUT_EASY = 3000,
  parameter int         TIMEOUT_HARD = 1500,
  parameter logic [6:0] SEED         = 7'h5A
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                jogar,
  input  logic                dificuldade,
  input  logic [N_BOTOES-1:0] botoes,
  output logic [W_ESTADO-1:0] estado,
  output logic [N_BOTOES-1:0] jogadas,
  output logic [W_PONTOS-1:0] pontuacao,
  output logic                pronto
);

  localparam int TMAX = (TIMEOUT_EASY > TIMEOUT_HARD) ? TIMEOUT_EASY : TIMEOUT_HARD;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int GW   = $clog2(GAP + 1);

  estado_t             state_q, state_d;
  logic                dif_q, dif_d;
  logic [W_PONTOS-1:0] score_q, score_d;
  logic [2:0]          round_q, round_d;
  logic [2:0]          target_q, target_d;
  logic [N_BOTOES-1:0] botoes_prev_q;

  logic [2:0]          idx;
  logic                gap_tc;
  logic                resp_tc;
  logic [N_BOTOES-1:0] press_edge;
  logic [N_BOTOES-1:0] target_oh;

  lfsr_alvo #(.SEED(SEED)) u_alvo (
    .clock    (clock),
    .reset    (reset),
    .prev_idx (target_q),
    .idx      (idx)
  );

  // Both timers are held at zero outside their state, so each visit starts
  // fresh: ESPERA lasts GAP cycles and MOSTRA at most the latched timeout.
  contador_m #(.W(GW)) u_gap (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (state_q != ESPERA),
    .enable_i (1'b1),
    .modulo_i (GW'(GAP)),
    .tc_o     (gap_tc)
  );

  contador_m #(.W(TW)) u_resp (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (state_q != MOSTRA),
    .enable_i (1'b1),
    .modulo_i (dif_q ? TW'(TIMEOUT_HARD) : TW'(TIMEOUT_EASY)),
    .tc_o     (resp_tc)
  );

  assign press_edge = botoes & ~botoes_prev_q;
  assign target_oh  = N_BOTOES'(1) << target_q;

  always_comb begin
    state_d  = state_q;
    dif_d    = dif_q;
    score_d  = score_q;
    round_d  = round_q;
    target_d = target_q;
    case (state_q)
      INICIAL, FIM: begin
        if (jogar) begin
          dif_d   = dificuldade;
          score_d = '0;
          round_d = '0;
          state_d = PREPARA;
        end
      end
      PREPARA: begin
        target_d = idx;
        state_d  = ESPERA;
      end
      ESPERA: begin
        if (gap_tc) state_d = MOSTRA;
      end
      MOSTRA: begin
        // A press edge wins over the timeout landing on the same cycle.
        if (press_edge != '0) begin
          state_d = (press_edge == target_oh) ? ACERTO : ERRO;
        end else if (resp_tc) begin
          state_d = ERRO;
        end
      end
      ACERTO: begin
        score_d = (score_q == '1) ? score_q : score_q + W_PONTOS'(1);
        round_d = round_q + 3'd1;
        state_d = PROXIMA;
      end
      ERRO: begin
        round_d = round_q + 3'd1;
        state_d = dif_q ? FIM : PROXIMA;
      end
      PROXIMA: begin
        state_d = (round_q == 3'(ROUNDS)) ? FIM : PREPARA;
      end
      default: state_d = INICIAL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= INICIAL;
      dif_q         <= 1'b0;
      score_q       <= '0;
      round_q       <= '0;
      target_q      <= SEM_ALVO;
      botoes_prev_q <= '0;
    end else begin
      state_q       <= state_d;
      dif_q         <= dif_d;
      score_q       <= score_d;
      round_q       <= round_d;
      target_q      <= target_d;
      botoes_prev_q <= botoes;
    end
  end

  assign estado    = state_q;
  assign jogadas   = (state_q == MOSTRA) ? target_oh : '0;
  assign pontuacao = score_q;
  assign pronto    = (state_q == FIM);

endmodule

// File: tb/tb_ovengame.sv
// tb/tb_ovengame.sv - directed and randomized rounds checked against a score/round model
module tb_ovengame;

  localparam int GAP    = 4;
  localparam int TE     = 10;
  localparam int TH     = 5;
  localparam int ROUNDS = 3;

  localparam int K_HIT   = 0;
  localparam int K_TO    = 1;
  localparam int K_WRONG = 2;
  localparam int K_BOTH  = 3;
  localparam int K_HITTO = 4;
  localparam int K_HELD  = 5;
  localparam int K_JOGAR = 6;

  logic       clock = 1'b0;
  logic       reset;
  logic       jogar;
  logic       dificuldade;
  logic [6:0] botoes;
  logic [3:0] estado;
  logic [6:0] jogadas;
  logic [2:0] pontuacao;
  logic       pronto;

  int checks = 0;
  int errors = 0;
  int m_score, m_round, m_hard, prev_tgt, rounds_total;
  bit done;

  always #5 clock = ~clock;

  ovengame #(
    .ROUNDS(ROUNDS), .GAP(GAP), .TIMEOUT_EASY(TE), .TIMEOUT_HARD(TH), .SEED(7'h5A)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .jogar       (jogar),
    .dificuldade (dificuldade),
    .botoes      (botoes),
    .estado      (estado),
    .jogadas     (jogadas),
    .pontuacao   (pontuacao),
    .pronto      (pronto)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_estado"}, estado, 32'h0);
    chk({tag, "_jogadas"}, jogadas, 32'h0);
    chk({tag, "_pontuacao"}, pontuacao, 32'h0);
    chk({tag, "_pronto"}, pronto, 32'h0);
  endtask

  task automatic start(input bit d);
    jogar = 1'b1;
    dificuldade = d;
    cyc();
    jogar = 1'b0;
    dificuldade = 1'($urandom_range(0, 1));
    chk("start_estado", estado, 32'h2);
    chk("start_pontuacao", pontuacao, 32'h0);
    chk("start_pronto", pronto, 32'h0);
    m_score = 0;
    m_round = 0;
    m_hard = int'(d);
    done = 1'b0;
  endtask

  task automatic end_game();
    chk("fim_estado", estado, 32'hF);
    chk("fim_pronto", pronto, 32'h1);
    chk("fim_jogadas", jogadas, 32'h0);
    chk("fim_pontuacao", pontuacao, 32'(m_score));
    done = 1'b1;
  endtask

  // Waits through ESPERA for the LED; returns target index or -1 on timeout.
  task automatic wait_led(output int tgt);
    int n;
    tgt = -1;
    cyc();
    chk("espera_estado", estado, 32'h3);
    n = 0;
    while (jogadas == 7'd0 && n < 50) begin
      cyc();
      n++;
    end
    chk("gap_length", 32'(n), 32'(GAP));
    if (jogadas == 7'd0) return;
    chk("mostra_estado", estado, 32'h4);
    chk("onehot", 32'($countones(jogadas)), 32'h1);
    for (int i = 0; i < 7; i++) if (jogadas[i]) tgt = i;
    if (prev_tgt >= 0) chk("no_repeat", 32'(tgt != prev_tgt), 32'h1);
    prev_tgt = tgt;
    rounds_total++;
  endtask

  task automatic play(input int kind, input int delay);
    int tgt, t_lim, o;
    logic [6:0] oh;
    bit hit;
    t_lim = (m_hard != 0) ? TH : TE;
    if (kind == K_HELD) botoes = 7'h7F;
    wait_led(tgt);
    if (tgt < 0) begin
      done = 1'b1;
      return;
    end
    oh = 7'b1 << tgt;
    o = $urandom_range(0, 5);
    if (o >= tgt) o++;
    hit = 1'b0;
    case (kind)
      K_HIT: begin
        repeat (delay) cyc();
        botoes = oh; hit = 1'b1;
      end
      K_JOGAR: begin
        jogar = 1'b1;
        cyc();
        jogar = 1'b0;
        chk("jogar_ignored", estado, 32'h4);
        repeat (delay - 1) cyc();
        botoes = oh; hit = 1'b1;
      end
      K_TO: begin
        repeat (t_lim - 1) cyc();
        chk("before_timeout", estado, 32'h4);
      end
      K_HITTO: begin
        repeat (t_lim - 1) cyc();
        botoes = oh; hit = 1'b1;
      end
      K_WRONG: begin
        repeat (delay) cyc();
        botoes = 7'b1 << o;
      end
      K_BOTH: begin
        repeat (delay) cyc();
        botoes = oh | (7'b1 << o);
      end
      default: begin
        repeat (2) cyc();
        chk("held_no_hit", estado, 32'h4);
        botoes = 7'h00;
        cyc();
        botoes = oh; hit = 1'b1;
      end
    endcase
    cyc();
    chk("resultado", estado, hit ? 32'h5 : 32'h6);
    botoes = 7'h00;
    if (hit) m_score = (m_score < 7) ? m_score + 1 : 7;
    m_round++;
    cyc();
    if (!hit && m_hard != 0) begin
      end_game();
      return;
    end
    chk("proxima_estado", estado, 32'h7);
    cyc();
    if (m_round == ROUNDS) end_game();
    else chk("prepara_estado", estado, 32'h2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int tgt, iter, guard, kind, lim;
    reset = 1'b1; jogar = 1'b0; dificuldade = 1'b0; botoes = 7'h00;
    prev_tgt = -1; rounds_total = 0;
    cyc(); cyc();
    chk_reset_outputs("reset");
    reset = 1'b0;
    cyc();
    chk("idle_estado", estado, 32'h0);

    start(1'b0);
    repeat (3) play(K_HIT, 3);

    start(1'b0);
    play(K_TO, 0); play(K_HIT, 2); play(K_HIT, 5);

    start(1'b1);
    play(K_HIT, 1); play(K_WRONG, 2);

    start(1'b0);
    play(K_HELD, 0); play(K_BOTH, 1); play(K_HITTO, 0);

    start(1'b0);
    play(K_JOGAR, 3);
    wait_led(tgt);
    reset = 1'b1;
    #1;
    chk_reset_outputs("mid_reset");
    cyc();
    reset = 1'b0;
    prev_tgt = -1;
    cyc();

    iter = 0;
    while (rounds_total < 60 && iter < 40) begin
      iter++;
      start(1'($urandom_range(0, 1)));
      guard = 0;
      while (!done && guard < 10) begin
        guard++;
        lim = (m_hard != 0) ? TH : TE;
        kind = $urandom_range(0, 6);
        play(kind, (kind == K_JOGAR) ? $urandom_range(1, lim - 1) : $urandom_range(0, lim - 1));
      end
    end
    chk("rounds_covered", 32'(rounds_total >= 50), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
